// File: rtl/menu_ctrl_if.sv
// menu_ctrl_if: groups the front-panel inputs (frame sync, four raw keys)
// and the display-facing outputs of the menu controller into one bundle.
//
// Modports:
//   master - the menu controller: samples vs_in and the keys, and drives
//            the cursor, mode and highlight outputs.
//   slave  - the board/mixer side: drives vs_in and the keys, and consumes
//            the cursor, mode and highlight outputs.
//
// Signals:
//   vs_in                       vertical sync, rising edge = frame boundary
//   key_{left,right,ok,back}_n  raw asynchronous push-buttons, active-low
//   cursor[1:0]                 live cursor index
//   mode[1:0]                   0 = menu, 1..3 = application (item + 1)
//   menu_en                     selects the menu background at the mixer
//   hl_valid                    highlight box is to be drawn
//   hl_x0/hl_x1                 inclusive highlight x bounds (X_BITS)
//   hl_y0/hl_y1                 inclusive highlight y bounds (Y_BITS)
interface menu_ctrl_if #(
  parameter int X_BITS = 13,
  parameter int Y_BITS = 13
);
  logic              vs_in;
  logic              key_left_n;
  logic              key_right_n;
  logic              key_ok_n;
  logic              key_back_n;
  logic [1:0]        cursor;
  logic [1:0]        mode;
  logic              menu_en;
  logic              hl_valid;
  logic [X_BITS-1:0] hl_x0;
  logic [X_BITS-1:0] hl_x1;
  logic [Y_BITS-1:0] hl_y0;
  logic [Y_BITS-1:0] hl_y1;

  modport master (
    input  vs_in, key_left_n, key_right_n, key_ok_n, key_back_n,
    output cursor, mode, menu_en, hl_valid, hl_x0, hl_x1, hl_y0, hl_y1
  );

  modport slave (
    output vs_in, key_left_n, key_right_n, key_ok_n, key_back_n,
    input  cursor, mode, menu_en, hl_valid, hl_x0, hl_x1, hl_y0, hl_y1
  );
endinterface

// File: rtl/menu_ctrl.sv
// menu_ctrl: front-panel menu controller for the instrument launcher.
// Debounces four active-low push-buttons, moves a cursor over the enabled
// menu items and launches/leaves an application mode. Every display-visible
// output (mode, menu_en, hl_valid, highlight bounds) changes only at a frame
// boundary so the renderer never tears mid-frame.
//
// Ports:
//   pix_clk - pixel clock, the only clock
//   rst     - synchronous active-high reset
//   bus     - menu_ctrl_if.master: vs_in and raw keys in; cursor, mode,
//             menu_en, hl_valid and highlight bounds out
//
// Optional feature macro:
//   MENU_WRAP_EN - when defined the cursor wraps between the lowest and the
//                  highest enabled item; otherwise it saturates there.
module menu_ctrl #(
  parameter int         X_BITS      = 13,
  parameter int         Y_BITS      = 13,
  parameter int         ITEM_NUM    = 3,
  parameter logic [2:0] ITEM_MASK   = 3'b110,
  parameter int         ITEM_X0     = 75,
  parameter int         ITEM_X_STEP = 315,
  parameter int         ITEM_W      = 240,
  parameter int         ITEM_Y0     = 300,
  parameter int         ITEM_H      = 48,
  parameter int         DEB_CYCLES  = 742500
) (
  input  logic        pix_clk,
  input  logic        rst,
  menu_ctrl_if.master bus
);

  localparam int                  CNT_BITS = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DEB_CYCLES);

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    ENTER = 2'd1,
    APP   = 2'd2,
    LEAVE = 2'd3
  } state_t;

  function automatic logic [1:0] lowest_item(input logic [2:0] mask);
    logic [1:0] res;
    logic       found;
    res   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (!found && mask[i]) begin
        res   = 2'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  localparam logic [1:0] LO_ITEM = lowest_item(ITEM_MASK);

`ifdef MENU_WRAP_EN
  function automatic logic [1:0] highest_item(input logic [2:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (mask[i]) res = 2'(i);
    end
    return res;
  endfunction

  localparam logic [1:0] HI_ITEM = highest_item(ITEM_MASK);
`endif

  // Next enabled item above cur; with a single enabled item nothing is
  // found and the cursor stays (or wraps onto itself).
  function automatic logic [1:0] step_right(input logic [1:0] cur);
    logic [1:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (!found && (i > int'(cur)) && ITEM_MASK[i]) begin
        res   = 2'(i);
        found = 1'b1;
      end
    end
`ifdef MENU_WRAP_EN
    if (!found) res = LO_ITEM;
`endif
    return res;
  endfunction

  function automatic logic [1:0] step_left(input logic [1:0] cur);
    logic [1:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = ITEM_NUM - 1; i >= 0; i--) begin
      if (!found && (i < int'(cur)) && ITEM_MASK[i]) begin
        res   = 2'(i);
        found = 1'b1;
      end
    end
`ifdef MENU_WRAP_EN
    if (!found) res = HI_ITEM;
`endif
    return res;
  endfunction

  function automatic logic [X_BITS-1:0] item_x0(input logic [1:0] idx);
    return X_BITS'(ITEM_X0) + X_BITS'(idx) * X_BITS'(ITEM_X_STEP);
  endfunction

  localparam logic [X_BITS-1:0] RST_X0 = item_x0(LO_ITEM);
  localparam logic [X_BITS-1:0] RST_X1 = RST_X0 + X_BITS'(ITEM_W);

  // Key bit order: 0 left, 1 right, 2 ok, 3 back.
  logic [3:0]          keys_raw;
  logic [3:0]          sync1;
  logic [3:0]          sync2;
  logic [3:0]          sync_prev;
  logic [3:0]          level;
  logic [3:0]          press;
  logic [CNT_BITS-1:0] deb_cnt [4];

  logic                vs_r;
  logic                vs_rr;
  logic                frame_edge;

  state_t              state, state_n;
  logic [1:0]          cursor, cursor_n;
  logic [1:0]          mode, mode_n;
  logic                menu_en, menu_en_n;
  logic                hl_valid, hl_valid_n;
  logic [X_BITS-1:0]   hl_x0, hl_x0_n;
  logic [X_BITS-1:0]   hl_x1, hl_x1_n;

  assign keys_raw = {bus.key_back_n, bus.key_ok_n, bus.key_right_n, bus.key_left_n};

  // sync_prev lags sync2 by one cycle so a level change can be seen.
  // Acceptance uses sync_prev, which has been stable for DEB_CYCLES compares
  // whenever the counter sits at its maximum. The press pulse is registered
  // together with the accepted level, so it lasts exactly one cycle.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      sync_prev <= 4'hF;
      level     <= 4'hF;
      press     <= 4'h0;
      for (int k = 0; k < 4; k++) deb_cnt[k] <= '0;
    end else begin
      sync1     <= keys_raw;
      sync2     <= sync1;
      sync_prev <= sync2;
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] != sync_prev[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] != CNT_MAX) begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
        press[k] <= 1'b0;
        if (deb_cnt[k] == CNT_MAX) begin
          level[k] <= sync_prev[k];
          press[k] <= level[k] & ~sync_prev[k];
        end
      end
    end
  end

  // Frame edge is the registered vs_in rise; commits land one cycle after
  // vs_in is first sampled high.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_r  <= 1'b0;
      vs_rr <= 1'b0;
    end else begin
      vs_r  <= bus.vs_in;
      vs_rr <= vs_r;
    end
  end

  assign frame_edge = vs_r & ~vs_rr;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state    <= MENU;
      cursor   <= LO_ITEM;
      mode     <= 2'd0;
      menu_en  <= 1'b1;
      hl_valid <= 1'b1;
      hl_x0    <= RST_X0;
      hl_x1    <= RST_X1;
    end else begin
      state    <= state_n;
      cursor   <= cursor_n;
      mode     <= mode_n;
      menu_en  <= menu_en_n;
      hl_valid <= hl_valid_n;
      hl_x0    <= hl_x0_n;
      hl_x1    <= hl_x1_n;
    end
  end

  // The highlight reload reads the current cursor, so a move arriving in
  // the same cycle as a frame edge is shown only at the following frame.
  always_comb begin
    state_n    = state;
    cursor_n   = cursor;
    mode_n     = mode;
    menu_en_n  = menu_en;
    hl_valid_n = hl_valid;
    hl_x0_n    = hl_x0;
    hl_x1_n    = hl_x1;
    case (state)
      MENU: begin
        if (frame_edge) begin
          hl_x0_n = item_x0(cursor);
          hl_x1_n = item_x0(cursor) + X_BITS'(ITEM_W);
        end
        if (press[2]) begin
          state_n = ENTER;
        end else if (press[1] && !press[0]) begin
          cursor_n = step_right(cursor);
        end else if (press[0] && !press[1]) begin
          cursor_n = step_left(cursor);
        end
      end
      ENTER: begin
        if (frame_edge) begin
          mode_n     = cursor + 2'd1;
          menu_en_n  = 1'b0;
          hl_valid_n = 1'b0;
          state_n    = APP;
        end
      end
      APP: begin
        if (press[3]) state_n = LEAVE;
      end
      LEAVE: begin
        if (frame_edge) begin
          mode_n     = 2'd0;
          menu_en_n  = 1'b1;
          hl_valid_n = 1'b1;
          state_n    = MENU;
        end
      end
      default: state_n = MENU;
    endcase
  end

  assign bus.cursor   = cursor;
  assign bus.mode     = mode;
  assign bus.menu_en  = menu_en;
  assign bus.hl_valid = hl_valid;
  assign bus.hl_x0    = hl_x0;
  assign bus.hl_x1    = hl_x1;
  // All items share one row, so the y bounds never change.
  assign bus.hl_y0    = Y_BITS'(ITEM_Y0);
  assign bus.hl_y1    = Y_BITS'(ITEM_Y0) + Y_BITS'(ITEM_H);

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: self-checking bench for menu_ctrl with DEB_CYCLES = 4,
// item mask 3'b110 and a frame every 200 cycles. A behavioural model of the
// menu (run-length debounce, enabled-item list, frame commits) is compared
// against the DUT every cycle, and directed scenarios add literal checks.
module tb_menu_ctrl;
  localparam int         DEB    = 4;
  localparam logic [2:0] MASK   = 3'b110;
  localparam int         NITEMS = 3;
`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  menu_ctrl_if #(.X_BITS(13), .Y_BITS(13)) bus ();

  menu_ctrl #(
    .X_BITS(13), .Y_BITS(13), .ITEM_NUM(NITEMS), .ITEM_MASK(MASK),
    .ITEM_X0(75), .ITEM_X_STEP(315), .ITEM_W(240), .ITEM_Y0(300),
    .ITEM_H(48), .DEB_CYCLES(DEB)
  ) dut (
    .pix_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Frame generator: vs_in high for 4 cycles out of every 200.
  initial begin
    int vcnt;
    vcnt = 0;
    bus.vs_in = 1'b0;
    forever begin
      @(negedge clk);
      vcnt++;
      bus.vs_in = ((vcnt % 200) < 4);
    end
  end

  // ---------------- behavioural model ----------------
  int m_cursor, m_mode, m_x0, m_x1;
  bit m_menu_en, m_hl_valid, m_app, m_pending, m_valid;
  bit m_pulse [4];
  bit m_lvl [4];
  bit m_val [4];
  int m_run [4];
  int m_due [4];
  bit m_due_lvl [4];
  int m_cyc;
  bit m_vs1, m_vs2;

  function automatic int move_cursor(int cur, int dir);
    int en[$];
    int pos;
    for (int i = 0; i < NITEMS; i++) if (MASK[i]) en.push_back(i);
    pos = 0;
    foreach (en[j]) if (en[j] == cur) pos = j;
    pos += dir;
    if (pos < 0) pos = WRAP ? en.size() - 1 : 0;
    else if (pos >= en.size()) pos = WRAP ? 0 : en.size() - 1;
    return en[pos];
  endfunction

  always @(posedge clk) begin
    bit fe;
    bit raw [4];
    raw[0] = bus.key_left_n;
    raw[1] = bus.key_right_n;
    raw[2] = bus.key_ok_n;
    raw[3] = bus.key_back_n;
    if (rst) begin
      m_cursor = 1; m_mode = 0; m_menu_en = 1; m_hl_valid = 1;
      m_x0 = 390; m_x1 = 630;
      m_app = 0; m_pending = 0; m_valid = 1;
      m_cyc = 0; m_vs1 = 0; m_vs2 = 0;
      for (int k = 0; k < 4; k++) begin
        m_pulse[k] = 0; m_lvl[k] = 1; m_val[k] = 1;
        m_run[k] = DEB + 1; m_due[k] = -1; m_due_lvl[k] = 1;
      end
    end else begin
      m_cyc++;
      fe = m_vs1 && !m_vs2;
      m_vs2 = m_vs1;
      m_vs1 = bus.vs_in;
      if (!m_app && !m_pending) begin
        if (fe) begin
          m_x0 = 75 + m_cursor * 315;
          m_x1 = m_x0 + 240;
        end
        if (m_pulse[2]) m_pending = 1;
        else if (m_pulse[1] && !m_pulse[0]) m_cursor = move_cursor(m_cursor, 1);
        else if (m_pulse[0] && !m_pulse[1]) m_cursor = move_cursor(m_cursor, -1);
      end else if (m_pending) begin
        if (fe) begin
          m_app = !m_app;
          m_pending = 0;
          m_mode = m_app ? m_cursor + 1 : 0;
          m_menu_en = !m_app;
          m_hl_valid = !m_app;
        end
      end else if (m_pulse[3]) begin
        m_pending = 1;
      end
      // A level held for DEB+1 samples is accepted three cycles later.
      for (int k = 0; k < 4; k++) begin
        m_pulse[k] = 0;
        if (m_due[k] == m_cyc) begin
          if (!m_due_lvl[k] && m_lvl[k]) m_pulse[k] = 1;
          m_lvl[k] = m_due_lvl[k];
          m_due[k] = -1;
        end
        if (raw[k] == m_val[k]) m_run[k]++;
        else begin
          m_val[k] = raw[k];
          m_run[k] = 1;
        end
        if (m_run[k] == DEB + 1) begin
          m_due[k] = m_cyc + 3;
          m_due_lvl[k] = raw[k];
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (bus.cursor !== 2'(m_cursor) || bus.mode !== 2'(m_mode) ||
          bus.menu_en !== m_menu_en || bus.hl_valid !== m_hl_valid ||
          bus.hl_x0 !== 13'(m_x0) || bus.hl_x1 !== 13'(m_x1) ||
          bus.hl_y0 !== 13'd300 || bus.hl_y1 !== 13'd348) begin
        $display("[TB] FAIL model_cmp t=%0t got/exp cursor %0d/%0d mode %0d/%0d menu_en %0d/%0d hl_valid %0d/%0d x0 %0d/%0d x1 %0d/%0d y0 %0d/300 y1 %0d/348",
                 $time, bus.cursor, m_cursor, bus.mode, m_mode, bus.menu_en, m_menu_en,
                 bus.hl_valid, m_hl_valid, bus.hl_x0, m_x0, bus.hl_x1, m_x1,
                 bus.hl_y0, bus.hl_y1);
      end else begin
        n_pass++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // keys_n bit order: {back, ok, right, left}, active-low.
  task automatic applyStimulus(input logic [3:0] keys_n);
    @(negedge clk);
    bus.key_left_n  = keys_n[0];
    bus.key_right_n = keys_n[1];
    bus.key_ok_n    = keys_n[2];
    bus.key_back_n  = keys_n[3];
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pressKeys(input logic [3:0] mask);
    applyStimulus(~mask);
    waitCycles(10);
    applyStimulus(4'hF);
    waitCycles(12);
  endtask

  // Returns at the negedge right after a frame commit.
  task automatic waitFrame();
    logic prev;
    bit   seen;
    seen = 0;
    @(posedge clk);
    prev = bus.vs_in;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk);
      if (bus.vs_in && !prev) seen = 1;
      prev = bus.vs_in;
    end
    if (!seen) begin
      n_checks++;
      $display("[TB] FAIL frame_timeout: got no vs_in rise expected one within 500 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nonzero;
    rst = 1'b1;
    bus.key_left_n = 1'b1; bus.key_right_n = 1'b1;
    bus.key_ok_n = 1'b1;   bus.key_back_n = 1'b1;
    waitCycles(3);
    rst = 1'b0;

    // 1. reset values
    checkOutput("rst_cursor", bus.cursor, 1);
    checkOutput("rst_mode", bus.mode, 0);
    checkOutput("rst_menu_en", bus.menu_en, 1);
    checkOutput("rst_hl_valid", bus.hl_valid, 1);
    checkOutput("rst_hl_x0", bus.hl_x0, 390);
    checkOutput("rst_hl_x1", bus.hl_x1, 630);
    checkOutput("rst_hl_y0", bus.hl_y0, 300);
    checkOutput("rst_hl_y1", bus.hl_y1, 348);

    // 2. short glitch ignored, held press moves cursor at change+8
    waitFrame();
    applyStimulus(4'b1101);
    waitCycles(2);
    applyStimulus(4'hF);
    waitCycles(15);
    checkOutput("glitch_cursor", bus.cursor, 1);
    applyStimulus(4'b1101);
    waitCycles(8);
    checkOutput("right_cursor_at_7", bus.cursor, 1);
    waitCycles(1);
    checkOutput("right_cursor_at_8", bus.cursor, 2);
    checkOutput("right_hl_x0_before_frame", bus.hl_x0, 390);
    waitCycles(10);
    applyStimulus(4'hF);
    waitCycles(12);
    waitFrame();
    checkOutput("right_hl_x0_after_frame", bus.hl_x0, 705);
    checkOutput("right_hl_x1_after_frame", bus.hl_x1, 945);

    // 3. boundary behaviour, item 0 disabled
    pressKeys(4'b0010);
    checkOutput("right_at_top", bus.cursor, WRAP ? 1 : 2);
    pressKeys(4'b0001);
    checkOutput("left_first", bus.cursor, WRAP ? 2 : 1);
    pressKeys(4'b0001);
    checkOutput("left_second", bus.cursor, 1);
    pressKeys(4'b0010);
    checkOutput("right_back_to_2", bus.cursor, 2);
    pressKeys(4'b0011);
    checkOutput("left_right_together", bus.cursor, 2);

    // 4. ok launches the application at the next frame
    waitFrame();
    pressKeys(4'b0100);
    checkOutput("ok_mode_before_frame", bus.mode, 0);
    checkOutput("ok_menu_en_before_frame", bus.menu_en, 1);
    waitFrame();
    checkOutput("app_mode", bus.mode, 3);
    checkOutput("app_menu_en", bus.menu_en, 0);
    checkOutput("app_hl_valid", bus.hl_valid, 0);
    pressKeys(4'b0001);
    pressKeys(4'b0010);
    pressKeys(4'b0100);
    checkOutput("app_cursor_frozen", bus.cursor, 2);
    waitFrame();
    checkOutput("app_mode_kept", bus.mode, 3);

    // 5. back leaves the application at the next frame
    pressKeys(4'b1000);
    checkOutput("back_mode_before_frame", bus.mode, 3);
    waitFrame();
    checkOutput("leave_mode", bus.mode, 0);
    checkOutput("leave_menu_en", bus.menu_en, 1);
    checkOutput("leave_hl_valid", bus.hl_valid, 1);
    checkOutput("leave_cursor", bus.cursor, 2);
    checkOutput("leave_hl_x0", bus.hl_x0, 705);

    // 6. reset while ENTER is pending discards the launch
    waitFrame();
    pressKeys(4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_enter_cursor", bus.cursor, 1);
    checkOutput("rst_enter_mode", bus.mode, 0);
    checkOutput("rst_enter_menu_en", bus.menu_en, 1);
    checkOutput("rst_enter_hl_x0", bus.hl_x0, 390);
    nonzero = 0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (bus.mode != 2'd0) nonzero++;
    end
    checkOutput("rst_enter_mode_never_set", nonzero, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/menu_ctrl.md
# menu_ctrl

Front-panel menu controller for the instrument launcher screen. Debounces four push-buttons, moves a cursor across the menu items drawn by the background renderer, and launches or leaves an application mode. All display-visible state changes are committed only at a frame boundary, so the renderer never tears mid-frame. Sits between the board keys and the background/overlay mixer in the `pix_clk` domain.

## Interface
Parameters:
- `X_BITS`, 13, width of x coordinates.
- `Y_BITS`, 13, width of y coordinates.
- `ITEM_NUM`, 3, number of menu items; legal range 1..3.
- `ITEM_MASK`, 3'b110, per-item enable; bit i set means item i is selectable.
- `ITEM_X0`, 75, left x of item 0.
- `ITEM_X_STEP`, 315, x pitch between items.
- `ITEM_W`, 240, item width in pixels.
- `ITEM_Y0`, 300, top y of all items.
- `ITEM_H`, 48, item height in pixels.
- `DEB_CYCLES`, 742500, stable-level cycles needed to accept a key (10 ms at 74.25 MHz); at least 2.

Ports:
- `pix_clk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `vs_in` in 1: vertical sync from the timing generator; its rising edge marks the frame boundary.
- `key_left_n`, `key_right_n`, `key_ok_n`, `key_back_n` in 1 each: raw asynchronous buttons, active-low.
- `cursor` out 2: live cursor index.
- `mode` out 2: 0 = menu; 1..3 = application (item index + 1). Frame-committed.
- `menu_en` out 1: 1 selects menu background at the mixer. Frame-committed.
- `hl_valid` out 1: highlight box is to be drawn. Frame-committed.
- `hl_x0`, `hl_x1` out X_BITS: inclusive highlight x bounds. Frame-committed.
- `hl_y0`, `hl_y1` out Y_BITS: inclusive highlight y bounds. Frame-committed.

## Operation
Key path (per key):
- Two-flop synchronizer.
- Counter resets on any level change and saturates at `DEB_CYCLES`.
- The accepted level updates when the count reaches `DEB_CYCLES`.
- A 1-cycle press pulse is generated on an accepted high→low transition. Release generates no pulse.

Cursor, applied in the cycle after a press pulse:
- In `MENU`, `right` moves to the next enabled item and `left` to the previous enabled item.
- Disabled items are skipped.
- Left and right pulses in the same cycle are both ignored.
- `ok` has priority over left/right in the same cycle; the cursor does not move.

FSM, 2-bit state:
- `MENU`: left/right move the cursor. `ok` → `ENTER`. `back` is ignored.
- `ENTER`: all keys ignored. On the frame edge: `mode`←`cursor`+1, `menu_en`←0, `hl_valid`←0, then → `APP`.
- `APP`: `back` → `LEAVE`. Other keys are ignored.
- `LEAVE`: all keys ignored. On the frame edge: `mode`←0, `menu_en`←1, `hl_valid`←1, then → `MENU`.
- While in `MENU`, each frame edge reloads the highlight bounds from `cursor`:
  - x0 = `ITEM_X0` + `cursor`·`ITEM_X_STEP`
  - x1 = x0 + `ITEM_W`
  - y0 = `ITEM_Y0`
  - y1 = `ITEM_Y0` + `ITEM_H`
- Highlight arithmetic is done at X_BITS/Y_BITS width, unsigned, with no overflow checks; the parameters must fit.
- If `ITEM_MASK` has a single enabled bit, left/right pulses leave the cursor unchanged.
- `ITEM_MASK` = 0 is illegal.

## Timing
- Frame edge: registered `vs_in` rising edge. Committed outputs update 1 cycle after `vs_in` is first sampled high.
- Key latency: a raw level change that is held produces a press pulse `DEB_CYCLES`+3 cycles after the change. The cursor moves 1 cycle later.
- A press pulse and a frame edge in the same cycle: the commit uses the pre-press cursor, and the move is shown at the next frame.
- An `ok` accepted in `MENU` enters `APP` at the first frame edge that is at least 1 cycle later.
- Reset values:
  - state `MENU`
  - `cursor` = lowest set bit of `ITEM_MASK` (1 by default)
  - `mode` 0, `menu_en` 1, `hl_valid` 1
  - highlight bounds precomputed for the reset cursor (390, 630, 300, 348 by default)
  - debounce counters 0
  - accepted key levels 1 (released)
  - synchronizers 1
- Reset mid-debounce or in `ENTER`/`LEAVE` discards the pending action. No pulse is issued after reset until a fresh press is accepted.

## Configuration
- `MENU_WRAP_EN` defined: right from the highest enabled item goes to the lowest enabled item, and left from the lowest goes to the highest.
- `MENU_WRAP_EN` undefined: the cursor saturates at the lowest/highest enabled item, and a move pulse at the boundary leaves it unchanged.

## Test plan
All scenarios use `DEB_CYCLES`=4, default mask 3'b110, and frames every 200 cycles.

1. Reset → `cursor`=1, `mode`=0, `menu_en`=1, `hl_x0`/`hl_x1`=390/630, `hl_y0`/`hl_y1`=300/348.
2. `key_right_n` low for 3 cycles then high → no pulse, `cursor` stays 1. Held low for 20 cycles → `cursor`=2 at change+8, and `hl_x0`=705 only after the next `vs_in` rise.
3. At `cursor`=2, right pulse → with `MENU_WRAP_EN` `cursor`=1; without it `cursor`=2. Left from 1 never yields 0 because item 0 is disabled.
4. `ok` press at `cursor`=2 → `mode` stays 0 until the next frame edge, then `mode`=3, `menu_en`=0, `hl_valid`=0. Left/right in `APP` → no change.
5. `back` in `APP` → at the frame edge `mode`=0, `menu_en`=1, `hl_valid`=1, and `cursor` is still 2.
6. Assert `rst` during `ENTER` → reset values on the next cycle, and `mode` never becomes nonzero.
